// File: rtl/seq_divider.sv
// Multi-cycle restoring divider: one quotient bit per clock, MSB first.
// Signed operations divide magnitudes, then fix the signs of the results.
module seq_divider #(
    parameter int WIDTH     = 8,
    parameter bit SIGNED_EN = 1'b1
) (
    input  logic             clock,
    input  logic             reset,
    input  logic             start,
    input  logic             signed_op,
    input  logic [WIDTH-1:0] x,
    input  logic [WIDTH-1:0] y,
    output logic             ready,
    output logic             valid,
    output logic [WIDTH-1:0] q,
    output logic [WIDTH-1:0] r,
    output logic             error
);

    localparam int CW = $clog2(WIDTH);

    typedef enum logic [1:0] {S_IDLE, S_RUN, S_FIX, S_DONE} state_t;

    state_t           state_reg, state_next;
    logic [CW-1:0]    cnt_reg;
    logic [WIDTH-1:0] mag_x_reg, mag_y_reg, rem_reg, quo_reg;
    logic             neg_q_reg, neg_r_reg;
    logic [WIDTH-1:0] q_reg, r_reg;
    logic             error_reg;

    logic             accept;
    logic             signed_mode;
    logic             x_neg, y_neg;
    logic [WIDTH-1:0] x_mag, y_mag;
    logic [WIDTH:0]   trial, diff;
    logic             bit_q;
    logic [WIDTH-1:0] rem_step;

    assign accept      = start && ((state_reg == S_IDLE) || (state_reg == S_DONE));
    assign signed_mode = SIGNED_EN && signed_op;
    assign x_neg       = signed_mode && x[WIDTH-1];
    assign y_neg       = signed_mode && y[WIDTH-1];
    assign x_mag       = x_neg ? (~x + 1'b1) : x;
    assign y_mag       = y_neg ? (~y + 1'b1) : y;

    // The borrow out of the trial subtraction doubles as the compare:
    // the partial remainder is always below mag_y, so diff fits in WIDTH+1 bits.
    assign trial    = {rem_reg, mag_x_reg[cnt_reg]};
    assign diff     = trial - {1'b0, mag_y_reg};
    assign bit_q    = ~diff[WIDTH];
    assign rem_step = bit_q ? diff[WIDTH-1:0] : trial[WIDTH-1:0];

    always_ff @(posedge clock or negedge reset) begin
        if (!reset) begin
            state_reg <= S_IDLE;
        end else begin
            state_reg <= state_next;
        end
    end

    always_comb begin
        state_next = state_reg;
        case (state_reg)
            S_IDLE, S_DONE: begin
                if (start) begin
                    state_next = (y == '0) ? S_DONE : S_RUN;
                end
            end
            S_RUN: begin
                if (cnt_reg == '0) begin
                    state_next = S_FIX;
                end
            end
            S_FIX:   state_next = S_DONE;
            default: state_next = S_IDLE;
        endcase
    end

    always_comb begin
        ready = (state_reg == S_IDLE) || (state_reg == S_DONE);
        valid = (state_reg == S_DONE);
    end

    always_ff @(posedge clock or negedge reset) begin
        if (!reset) begin
            cnt_reg   <= '0;
            mag_x_reg <= '0;
            mag_y_reg <= '0;
            rem_reg   <= '0;
            quo_reg   <= '0;
            neg_q_reg <= 1'b0;
            neg_r_reg <= 1'b0;
            q_reg     <= '0;
            r_reg     <= '0;
            error_reg <= 1'b0;
        end else if (accept) begin
            cnt_reg   <= CW'(WIDTH - 1);
            mag_x_reg <= x_mag;
            mag_y_reg <= y_mag;
            rem_reg   <= '0;
            quo_reg   <= '0;
            neg_q_reg <= x_neg ^ y_neg;
            neg_r_reg <= x_neg;
            if (y == '0) begin
                q_reg     <= '1;
                r_reg     <= x;
                error_reg <= 1'b1;
            end
        end else if (state_reg == S_RUN) begin
            rem_reg <= rem_step;
            quo_reg <= {quo_reg[WIDTH-2:0], bit_q};
            if (cnt_reg != '0) begin
                cnt_reg <= cnt_reg - 1'b1;
            end
        end else if (state_reg == S_FIX) begin
            q_reg     <= neg_q_reg ? (~quo_reg + 1'b1) : quo_reg;
            r_reg     <= neg_r_reg ? (~rem_reg + 1'b1) : rem_reg;
            error_reg <= 1'b0;
        end
    end

    assign q     = q_reg;
    assign r     = r_reg;
    assign error = error_reg;

endmodule

// File: tb/tb_seq_divider.sv
// Bench for seq_divider: a runtime-signed instance and a forced-unsigned
// instance share stimulus; results are compared against an arithmetic model.
module tb_seq_divider;

    logic       clock = 1'b0;
    logic       reset = 1'b0;
    logic       start = 1'b0;
    logic       signed_op = 1'b0;
    logic [7:0] x = '0;
    logic [7:0] y = '0;

    logic       ready0, valid0, error0;
    logic [7:0] q0, r0;
    logic       ready1, valid1, error1;
    logic [7:0] q1, r1;

    int checks = 0;
    int failures = 0;

    always #5 clock = ~clock;

    seq_divider #(.WIDTH(8), .SIGNED_EN(1'b1)) dut0 (
        .clock(clock), .reset(reset), .start(start), .signed_op(signed_op),
        .x(x), .y(y), .ready(ready0), .valid(valid0), .q(q0), .r(r0), .error(error0)
    );

    seq_divider #(.WIDTH(8), .SIGNED_EN(1'b0)) dut1 (
        .clock(clock), .reset(reset), .start(start), .signed_op(signed_op),
        .x(x), .y(y), .ready(ready1), .valid(valid1), .q(q1), .r(r1), .error(error1)
    );

    // Truncating division from plain integer arithmetic.
    function automatic void model(input logic [7:0] a, input logic [7:0] b, input bit s,
                                  output logic [7:0] mq, output logic [7:0] mr, output bit me);
        int sa, sb, tq, tr;
        if (b == 8'd0) begin
            mq = 8'hFF;
            mr = a;
            me = 1'b1;
        end else if (s) begin
            sa = int'($signed(a));
            sb = int'($signed(b));
            tq = sa / sb;
            tr = sa % sb;
            mq = tq[7:0];
            mr = tr[7:0];
            me = 1'b0;
        end else begin
            mq = a / b;
            mr = a % b;
            me = 1'b0;
        end
    endfunction

    // Starts one operation and waits (bounded) for valid; lat=-1 on timeout.
    task automatic issue(input logic [7:0] a, input logic [7:0] b, input bit s,
                         output int lat, output bit ready_ok);
        x = a; y = b; signed_op = s; start = 1'b1;
        @(posedge clock); #1;
        start = 1'b0;
        lat = 1;
        ready_ok = 1'b1;
        while (!valid0 && lat < 200) begin
            if (ready0) ready_ok = 1'b0;
            @(posedge clock); #1;
            lat++;
        end
        if (!valid0) lat = -1;
        $display("op x=%h y=%h s=%0d -> q=%h r=%h err=%0d lat=%0d", a, b, s, q0, r0, error0, lat);
    endtask

    task automatic test_reset();
        reset = 1'b0;
        #12;
        checks++; if (ready0 !== 1'b1) begin failures++; $display("FAIL reset_ready got %b want 1", ready0); end
        checks++; if (valid0 !== 1'b0) begin failures++; $display("FAIL reset_valid got %b want 0", valid0); end
        checks++; if (q0 !== 8'h00) begin failures++; $display("FAIL reset_q got %h want 00", q0); end
        checks++; if (r0 !== 8'h00) begin failures++; $display("FAIL reset_r got %h want 00", r0); end
        checks++; if (error0 !== 1'b0) begin failures++; $display("FAIL reset_error got %b want 0", error0); end
        reset = 1'b1;
        @(posedge clock); #1;
        $display("reset released");
    endtask

    typedef struct {
        logic [7:0] a, b;
        bit         s;
        logic [7:0] eq, er;
        bit         ee;
        int         lat;
    } vec_t;

    task automatic test_directed();
        vec_t vt[7];
        int lat;
        bit rok;
        logic [7:0] uq, ur;
        bit ue;
        vt[0] = '{8'd200, 8'd7,  1'b0, 8'd28,  8'd4,  1'b0, 10};
        vt[1] = '{8'hF9,  8'h02, 1'b1, 8'hFD,  8'hFF, 1'b0, 10};
        vt[2] = '{8'h07,  8'hFE, 1'b1, 8'hFD,  8'h01, 1'b0, 10};
        vt[3] = '{8'hF9,  8'h02, 1'b0, 8'd124, 8'd1,  1'b0, 10};
        vt[4] = '{8'h55,  8'h00, 1'b0, 8'hFF,  8'h55, 1'b1, 1};
        vt[5] = '{8'd9,   8'd3,  1'b0, 8'd3,   8'd0,  1'b0, 10};
        vt[6] = '{8'h80,  8'hFF, 1'b1, 8'h80,  8'h00, 1'b0, 10};
        foreach (vt[i]) begin
            issue(vt[i].a, vt[i].b, vt[i].s, lat, rok);
            checks++; if (lat != vt[i].lat) begin failures++; $display("FAIL dir%0d_latency got %0d want %0d", i, lat, vt[i].lat); end
            checks++; if (!rok) begin failures++; $display("FAIL dir%0d_ready_low got high want low", i); end
            checks++; if (q0 !== vt[i].eq) begin failures++; $display("FAIL dir%0d_q got %h want %h", i, q0, vt[i].eq); end
            checks++; if (r0 !== vt[i].er) begin failures++; $display("FAIL dir%0d_r got %h want %h", i, r0, vt[i].er); end
            checks++; if (error0 !== vt[i].ee) begin failures++; $display("FAIL dir%0d_error got %b want %b", i, error0, vt[i].ee); end
            model(vt[i].a, vt[i].b, 1'b0, uq, ur, ue);
            checks++; if (q1 !== uq || r1 !== ur || error1 !== ue) begin
                failures++;
                $display("FAIL dir%0d_unsigned_inst got q=%h r=%h e=%b want q=%h r=%h e=%b", i, q1, r1, error1, uq, ur, ue);
            end
        end
        // Unsigned-only instance ignores signed_op on the most-negative case
        checks++; if (q1 !== 8'h00 || r1 !== 8'h80) begin
            failures++; $display("FAIL unsigned_forced got q=%h r=%h want q=00 r=80", q1, r1);
        end
    endtask

    task automatic test_ignore_start();
        int lat;
        x = 8'd100; y = 8'd9; signed_op = 1'b0; start = 1'b1;
        @(posedge clock); #1;
        start = 1'b0;
        lat = 1;
        repeat (3) begin @(posedge clock); #1; lat++; end
        x = 8'd50; y = 8'd3; signed_op = 1'b1; start = 1'b1;
        @(posedge clock); #1; lat++;
        start = 1'b0; x = 8'd0; y = 8'd0;
        while (!valid0 && lat < 200) begin @(posedge clock); #1; lat++; end
        $display("op ignore-start q=%h r=%h lat=%0d", q0, r0, lat);
        checks++; if (lat != 10) begin failures++; $display("FAIL ignore_latency got %0d want 10", lat); end
        checks++; if (q0 !== 8'd11) begin failures++; $display("FAIL ignore_q got %h want 0b", q0); end
        checks++; if (r0 !== 8'd1) begin failures++; $display("FAIL ignore_r got %h want 01", r0); end
    endtask

    task automatic test_back_to_back();
        int lat;
        x = 8'd20; y = 8'd6; signed_op = 1'b0; start = 1'b1;
        @(posedge clock); #1;
        lat = 1;
        while (!valid0 && lat < 200) begin @(posedge clock); #1; lat++; end
        $display("op b2b first q=%h r=%h lat=%0d", q0, r0, lat);
        checks++; if (lat != 10) begin failures++; $display("FAIL b2b_first_latency got %0d want 10", lat); end
        checks++; if (q0 !== 8'd3 || r0 !== 8'd2) begin failures++; $display("FAIL b2b_first got q=%h r=%h want q=03 r=02", q0, r0); end
        x = 8'd100; y = 8'd7;
        @(posedge clock); #1;
        start = 1'b0;
        checks++; if (valid0 !== 1'b0) begin failures++; $display("FAIL b2b_valid_drop got %b want 0", valid0); end
        checks++; if (ready0 !== 1'b0) begin failures++; $display("FAIL b2b_ready_drop got %b want 0", ready0); end
        lat = 1;
        while (!valid0 && lat < 200) begin @(posedge clock); #1; lat++; end
        $display("op b2b second q=%h r=%h lat=%0d", q0, r0, lat);
        checks++; if (lat != 10) begin failures++; $display("FAIL b2b_second_latency got %0d want 10", lat); end
        checks++; if (q0 !== 8'd14 || r0 !== 8'd2) begin failures++; $display("FAIL b2b_second got q=%h r=%h want q=0e r=02", q0, r0); end
    endtask

    task automatic test_reset_midrun();
        int lat;
        bit rok;
        x = 8'd200; y = 8'd7; signed_op = 1'b0; start = 1'b1;
        @(posedge clock); #1;
        start = 1'b0;
        repeat (3) @(posedge clock);
        #3 reset = 1'b0;
        #1;
        $display("reset mid-run ready=%b valid=%b q=%h r=%h", ready0, valid0, q0, r0);
        checks++; if (ready0 !== 1'b1) begin failures++; $display("FAIL midrst_ready got %b want 1", ready0); end
        checks++; if (valid0 !== 1'b0) begin failures++; $display("FAIL midrst_valid got %b want 0", valid0); end
        checks++; if (q0 !== 8'h00 || r0 !== 8'h00) begin failures++; $display("FAIL midrst_qr got q=%h r=%h want 00 00", q0, r0); end
        checks++; if (error0 !== 1'b0) begin failures++; $display("FAIL midrst_error got %b want 0", error0); end
        #2 reset = 1'b1;
        @(posedge clock); #1;
        checks++; if (valid0 !== 1'b0) begin failures++; $display("FAIL midrst_no_result got %b want 0", valid0); end
        issue(8'd255, 8'd16, 1'b0, lat, rok);
        checks++; if (lat != 10) begin failures++; $display("FAIL post_rst_latency got %0d want 10", lat); end
        checks++; if (q0 !== 8'd15 || r0 !== 8'd15) begin failures++; $display("FAIL post_rst got q=%h r=%h want 0f 0f", q0, r0); end
    endtask

    task automatic test_random();
        int lat;
        bit rok;
        logic [7:0] a, b, eq, er, uq, ur;
        bit s, ee, ue;
        for (int n = 0; n < 40; n++) begin
            a = 8'($urandom_range(0, 255));
            b = ($urandom_range(0, 7) == 0) ? 8'd0 : 8'($urandom_range(0, 255));
            s = 1'($urandom_range(0, 1));
            model(a, b, s, eq, er, ee);
            model(a, b, 1'b0, uq, ur, ue);
            issue(a, b, s, lat, rok);
            checks++; if (lat != ((b == 8'd0) ? 1 : 10)) begin failures++; $display("FAIL rnd%0d_latency got %0d", n, lat); end
            checks++; if (!rok) begin failures++; $display("FAIL rnd%0d_ready_low got high want low", n); end
            checks++; if (q0 !== eq || r0 !== er || error0 !== ee) begin
                failures++;
                $display("FAIL rnd%0d_signed_inst x=%h y=%h s=%0d got q=%h r=%h e=%b want q=%h r=%h e=%b", n, a, b, s, q0, r0, error0, eq, er, ee);
            end
            checks++; if (q1 !== uq || r1 !== ur || error1 !== ue || valid1 !== 1'b1) begin
                failures++;
                $display("FAIL rnd%0d_unsigned_inst got q=%h r=%h e=%b v=%b want q=%h r=%h e=%b v=1", n, q1, r1, error1, valid1, uq, ur, ue);
            end
        end
    endtask

    initial begin
        test_reset();
        test_directed();
        test_ignore_start();
        test_back_to_back();
        test_reset_midrun();
        test_random();
        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
